// File: rtl/instr_mem_pkg.sv
// Purpose : shared types and default sizing for the loadable instruction memory.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package instr_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = 16'h0000;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    // RAM index width; a one-word RAM still needs a one-bit address.
    function automatic int ram_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Purpose : single-port synchronous RAM holding the program words.
// Latency : write lands on the clock edge; read data is registered, 1 cycle after re.
// Backpressure : none; caller guarantees we and re are never asserted together.
//
// Ports: clk; we/wdata write port; re read strobe; addr shared word address;
//        rdata registered read data, holds its value while re is low.
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = ram_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or the read register: contents are only ever
    // observed through the prog_len gate in the parent.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Purpose : run-time loadable instruction store: valid/ready load stream, then registered fetch port.
// Latency : fetch data/err 1 cycle after fetch_req; load word written on the accepting edge.
// Backpressure : load_ready high only in LOAD; fetch port has no backpressure (1 fetch/cycle in RUN).
//
// Ports: clk, rst_n (sync, active-low); load_valid/load_data/load_last/load_ready load stream;
//        start_load returns RUN to LOAD; fetch_req/fetch_addr request, fetch_valid/fetch_data/
//        fetch_err response; running = in RUN; prog_len = number of words loaded.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start_load,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    output logic              running,
    output logic [ADDR_W:0]   prog_len
);

    localparam int                RAM_AW   = ram_aw(DEPTH);
    localparam int                LEN_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] WP_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wp_q;
    logic [LEN_W-1:0]  prog_len_q;
    logic              load_acc, load_end, fetch_go, in_range;
    logic              fetch_valid_q, fetch_err_q;
    logic              nop_sel_q;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d  = state_q;
        load_acc = 1'b0;
        load_end = 1'b0;
        fetch_go = 1'b0;
        // Zero-extend so addresses at or past DEPTH compare as out of range.
        in_range = ({1'b0, fetch_addr} < prog_len_q);
        case (state_q)
            ST_LOAD: begin
                load_acc = load_valid;
                // Filling the last slot ends the load even without load_last.
                load_end = load_valid && (load_last || (wp_q == WP_LAST));
                if (load_end) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A fetch alongside start_load is still served from current contents.
                fetch_go = fetch_req;
                if (start_load) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            wp_q          <= '0;
            prog_len_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_go;
            if (fetch_go) begin
                fetch_err_q <= !in_range;
                nop_sel_q   <= !in_range;
            end
            if (load_acc) begin
                wp_q <= wp_q + ADDR_W'(1);
            end
            if (load_end) begin
                prog_len_q <= load_last ? ({1'b0, wp_q} + LEN_W'(1)) : LEN_FULL;
            end
            if ((state_q == ST_RUN) && start_load) begin
                wp_q       <= '0;
                prog_len_q <= '0;
            end
        end
    end

    // LOAD writes at wp, RUN reads at fetch_addr: the single port is never contended.
    assign ram_addr = (state_q == ST_RUN) ? fetch_addr[RAM_AW-1:0] : wp_q[RAM_AW-1:0];

    instr_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (load_acc),
        .re    (fetch_go && in_range),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

    // nop_sel_q is separate from fetch_err_q because after reset the data must
    // read NOP_WORD while the error flag reads 0; the RAM read register is
    // unknown until the first in-range fetch.
    assign fetch_data  = nop_sel_q ? NOP_WORD : ram_rdata;
    assign fetch_err   = fetch_err_q;
    assign fetch_valid = fetch_valid_q;
    assign running     = (state_q == ST_RUN);
    assign load_ready  = (state_q == ST_LOAD);
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance a: default sizing; instance b: DEPTH=8 for the overflow case
    logic        a_load_valid, a_load_last, a_load_ready, a_start_load, a_fetch_req;
    logic [15:0] a_load_data, a_fetch_data;
    logic [7:0]  a_fetch_addr;
    logic        a_fetch_valid, a_fetch_err, a_running;
    logic [8:0]  a_prog_len;

    logic        b_load_valid, b_load_last, b_load_ready, b_start_load, b_fetch_req;
    logic [15:0] b_load_data, b_fetch_data;
    logic [7:0]  b_fetch_addr;
    logic        b_fetch_valid, b_fetch_err, b_running;
    logic [8:0]  b_prog_len;

    instr_mem_loadable dut_a (
        .clk(clk), .rst_n(rst_n),
        .load_valid(a_load_valid), .load_data(a_load_data), .load_last(a_load_last),
        .load_ready(a_load_ready), .start_load(a_start_load),
        .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr),
        .fetch_valid(a_fetch_valid), .fetch_data(a_fetch_data), .fetch_err(a_fetch_err),
        .running(a_running), .prog_len(a_prog_len)
    );

    instr_mem_loadable #(.DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .load_valid(b_load_valid), .load_data(b_load_data), .load_last(b_load_last),
        .load_ready(b_load_ready), .start_load(b_start_load),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr),
        .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data), .fetch_err(b_fetch_err),
        .running(b_running), .prog_len(b_prog_len)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;
    exp_t last_a = '{err: 1'b0, data: 16'h0000};
    exp_t last_b = '{err: 1'b0, data: 16'h0000};
    logic [15:0] prog [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one edge, then check the response port of both instances.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("a_fetch_valid", {31'd0, a_fetch_valid}, {31'd0, pend_a});
        if (pend_a) begin
            if (q_a.size() == 0) begin
                chk("a_scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                last_a = e;
            end
        end
        chk("a_fetch_data", {16'd0, a_fetch_data}, {16'd0, last_a.data});
        chk("a_fetch_err", {31'd0, a_fetch_err}, {31'd0, last_a.err});
        chk("b_fetch_valid", {31'd0, b_fetch_valid}, {31'd0, pend_b});
        if (pend_b) begin
            if (q_b.size() == 0) begin
                chk("b_scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                last_b = e;
            end
        end
        chk("b_fetch_data", {16'd0, b_fetch_data}, {16'd0, last_b.data});
        chk("b_fetch_err", {31'd0, b_fetch_err}, {31'd0, last_b.err});
        pend_a = 1'b0;
        pend_b = 1'b0;
        a_fetch_req = 1'b0;
        b_fetch_req = 1'b0;
        a_start_load = 1'b0;
        b_start_load = 1'b0;
        a_load_valid = 1'b0;
        b_load_valid = 1'b0;
    endtask

    task automatic fetch_a(input logic [7:0] addr, input logic served, input logic err,
                           input logic [15:0] data);
        a_fetch_req = 1'b1;
        a_fetch_addr = addr;
        pend_a = served;
        if (served) q_a.push_back('{err: err, data: data});
    endtask

    task automatic fetch_b(input logic [7:0] addr, input logic served, input logic err,
                           input logic [15:0] data);
        b_fetch_req = 1'b1;
        b_fetch_addr = addr;
        pend_b = served;
        if (served) q_b.push_back('{err: err, data: data});
    endtask

    task automatic load_a(input logic [15:0] w, input logic last);
        a_load_valid = 1'b1;
        a_load_data = w;
        a_load_last = last;
    endtask

    initial begin
        prog[0] = 16'hC000;
        prog[1] = 16'hC104;
        prog[2] = 16'hC30A;
        prog[3] = 16'h8008;
        rst_n = 1'b0;
        a_load_valid = 1'b1; a_load_data = 16'hBEEF; a_load_last = 1'b1;
        b_load_valid = 1'b1; b_load_data = 16'hBEEF; b_load_last = 1'b1;
        a_start_load = 1'b0; b_start_load = 1'b0;
        a_fetch_req = 1'b0; a_fetch_addr = 8'd0;
        b_fetch_req = 1'b0; b_fetch_addr = 8'd0;

        // reset held 3 cycles with load_valid asserted: nothing is accepted
        for (int i = 0; i < 3; i++) begin
            a_load_valid = 1'b1;
            b_load_valid = 1'b1;
            tick();
        end
        chk("rst_a_load_ready", {31'd0, a_load_ready}, 32'd1);
        chk("rst_a_running", {31'd0, a_running}, 32'd0);
        chk("rst_a_prog_len", {23'd0, a_prog_len}, 32'd0);
        chk("rst_b_prog_len", {23'd0, b_prog_len}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_a_running", {31'd0, a_running}, 32'd0);
        chk("post_rst_a_prog_len", {23'd0, a_prog_len}, 32'd0);

        // 4-word load; a fetch during LOAD must produce no pulse
        for (int i = 0; i < 4; i++) begin
            chk("load_a_ready", {31'd0, a_load_ready}, 32'd1);
            load_a(prog[i], i == 3);
            if (i == 0) fetch_a(8'd0, 1'b0, 1'b0, 16'h0);
            tick();
        end
        chk("load_a_running", {31'd0, a_running}, 32'd1);
        chk("load_a_prog_len", {23'd0, a_prog_len}, 32'd4);
        chk("load_a_ready_low", {31'd0, a_load_ready}, 32'd0);

        // first RUN cycle sees the just-written word, then 0..3 back-to-back
        fetch_a(8'd3, 1'b1, 1'b0, prog[3]);
        tick();
        for (int i = 0; i < 4; i++) begin
            fetch_a(8'(i), 1'b1, 1'b0, prog[i]);
            tick();
        end

        // out of range, then back in range clears the error
        fetch_a(8'd4, 1'b1, 1'b1, 16'h0000);
        tick();
        fetch_a(8'd255, 1'b1, 1'b1, 16'h0000);
        tick();
        fetch_a(8'd2, 1'b1, 1'b0, prog[2]);
        tick();
        tick();

        // overflow on the 8-deep instance: 10 words, no last
        for (int i = 0; i < 10; i++) begin
            chk("ovf_b_ready", {31'd0, b_load_ready}, (i < 8) ? 32'd1 : 32'd0);
            b_load_valid = 1'b1;
            b_load_data = 16'h5A00 + 16'(i);
            b_load_last = 1'b0;
            tick();
            if (i == 7) begin
                chk("ovf_b_running", {31'd0, b_running}, 32'd1);
                chk("ovf_b_prog_len", {23'd0, b_prog_len}, 32'd8);
            end
        end
        chk("ovf_b_prog_len_hold", {23'd0, b_prog_len}, 32'd8);
        fetch_b(8'd7, 1'b1, 1'b0, 16'h5A07);
        tick();
        fetch_b(8'd0, 1'b1, 1'b0, 16'h5A00);
        tick();
        fetch_b(8'd8, 1'b1, 1'b1, 16'h0000);
        tick();

        // reload: start_load with a same-cycle fetch served from old contents
        a_start_load = 1'b1;
        fetch_a(8'd1, 1'b1, 1'b0, 16'hC104);
        tick();
        chk("reload_a_running", {31'd0, a_running}, 32'd0);
        chk("reload_a_prog_len", {23'd0, a_prog_len}, 32'd0);
        chk("reload_a_ready", {31'd0, a_load_ready}, 32'd1);
        a_start_load = 1'b1;   // ignored while loading
        load_a(16'hD3C8, 1'b1);
        tick();
        chk("reload_a_running2", {31'd0, a_running}, 32'd1);
        chk("reload_a_prog_len2", {23'd0, a_prog_len}, 32'd1);
        fetch_a(8'd0, 1'b1, 1'b0, 16'hD3C8);
        tick();
        fetch_a(8'd1, 1'b1, 1'b1, 16'h0000);
        tick();
        fetch_a(8'd0, 1'b1, 1'b0, 16'hD3C8);
        tick();

        // reset mid-run overrides a pending fetch
        rst_n = 1'b0;
        fetch_a(8'd0, 1'b0, 1'b0, 16'h0);
        last_a = '{err: 1'b0, data: 16'h0000};
        last_b = '{err: 1'b0, data: 16'h0000};
        tick();
        chk("midrst_a_running", {31'd0, a_running}, 32'd0);
        chk("midrst_a_prog_len", {23'd0, a_prog_len}, 32'd0);
        chk("midrst_a_ready", {31'd0, a_load_ready}, 32'd1);
        chk("midrst_b_running", {31'd0, b_running}, 32'd0);
        rst_n = 1'b1;
        tick();

        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
